renode_apb3_manager_engine: RTL

- APB3 requester (manager) engine for the co-simulation integration library; the counterpart of the APB3 completer side.
- Accepts single read/write commands from the Renode-facing side over a valid/ready request channel.
- Drives one APB3 SETUP/ACCESS transfer per command and returns read data and status over a valid/ready response channel.
- Bounded wait-state timeout so a hung completer cannot stall the simulation.

---
 rtl/renode_apb3_pkg.sv | 9 +
 rtl/renode_apb3_timeout_counter.sv | 29 ++
 rtl/renode_apb3_manager_engine.sv | 101 ++++++++++
 3 files changed

// File: rtl/renode_apb3_pkg.sv
// Shared types and helpers for the Renode APB3 manager engine.
package renode_apb3_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPOND} apb3_mgr_state_e;

  // Counter must hold TimeoutCycles itself so saturation never aliases the last value.
  function automatic int tmo_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/renode_apb3_timeout_counter.sv
// Saturating ACCESS-phase wait-state counter; flags the last allowed cycle.
module renode_apb3_timeout_counter
  import renode_apb3_pkg::*;
#(
  parameter int TimeoutCycles = 1024
) (
  input  logic pclk,
  input  logic presetn,
  input  logic enable,
  input  logic clear,
  output logic expired
);
  localparam int CW = tmo_cnt_w(TimeoutCycles);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] count;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                          count <= '0;
    else if (clear)                        count <= '0;
    else if (enable && count != CNT_MAX)   count <= count + 1'b1;
  end

  if (TimeoutCycles == 0) begin : g_no_tmo
    assign expired = 1'b0;
  end else begin : g_tmo
    assign expired = (count == CW'(TimeoutCycles - 1));
  end
endmodule

// File: rtl/renode_apb3_manager_engine.sv
// APB3 requester: one SETUP/ACCESS transfer per command, response held until consumed.
module renode_apb3_manager_engine
  import renode_apb3_pkg::*;
#(
  parameter int AddressWidth  = 20,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [AddressWidth-1:0] req_addr,
  input  logic [DataWidth-1:0]    req_wdata,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DataWidth-1:0]    rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic [AddressWidth-1:0] paddr,
  output logic                    pselx,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DataWidth-1:0]    pwdata,
  input  logic                    pready,
  input  logic [DataWidth-1:0]    prdata,
  input  logic                    pslverr
);
  if (!(DataWidth == 8 || DataWidth == 16 || DataWidth == 24 || DataWidth == 32)) begin : g_dw_check
    $error("renode_apb3_manager_engine: DataWidth must be 8, 16, 24 or 32");
  end

  apb3_mgr_state_e state;
  logic            tmo_expired;

  assign req_ready = (state == IDLE);

  renode_apb3_timeout_counter #(.TimeoutCycles(TimeoutCycles)) u_tmo (
    .pclk    (pclk),
    .presetn (presetn),
    .enable  ((state == ACCESS) && !pready),
    .clear   (state != ACCESS),
    .expired (tmo_expired)
  );

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state       <= IDLE;
      paddr       <= '0;
      pselx       <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          paddr   <= req_addr;
          pwrite  <= req_write;
          pwdata  <= req_write ? req_wdata : '0;
          pselx   <= 1'b1;
          penable <= 1'b0;
          state   <= SETUP;
        end
        SETUP: begin
          penable <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          // pready takes priority over a coincident timeout
          if (pready) begin
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_error   <= pslverr;
            rsp_timeout <= 1'b0;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESPOND;
          end else if (tmo_expired) begin
            rsp_rdata   <= '0;
            rsp_error   <= 1'b1;
            rsp_timeout <= 1'b1;
            pselx       <= 1'b0;
            penable     <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= RESPOND;
          end
        end
        RESPOND: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
